button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the five raw Nexys A7 push-buttons before they reach the game block. Each button is synchronised into pixel_clk, debounced, and delivered as a clean level plus single-cycle press/release strobes. btn_press[0] (centre) drives the game's regime change as a one-cycle event; btn_level[4:1] drive object movement.

## Interface

Parameters:
- N_BTN, 5, number of buttons; bit order c, u, d, r, l = [0]..[4].
- DEBOUNCE_CYCLES, 252000, consecutive stable cycles required to accept a new state (10 ms at 25.2 MHz); legal range ≥ 1.
- REPEAT_DELAY, 12600000, hold cycles before the first auto-repeat strobe (0.5 s); used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 2520000, cycles between later auto-repeat strobes (0.1 s); used only with BTN_AUTOREPEAT_EN.
- REPEAT_MASK, 5'b11110, per-button auto-repeat enable; the centre button never repeats by default.

Ports:
- pixel_clk  in  1  pixel clock, 25.2 MHz.
- rst_n  in  1  synchronous, active-low reset.
- btn_raw  in  N_BTN  asynchronous raw button inputs, active high.
- btn_level  out  N_BTN  debounced button state, registered.
- btn_press  out  N_BTN  one-cycle strobe on an accepted 0→1 transition (and on auto-repeat).
- btn_release  out  N_BTN  one-cycle strobe on an accepted 1→0 transition.

## Operation

- Synchroniser: two flops per button (sync1, sync2), both reset to 0. Only sync2 feeds the debouncer.
- Debouncer, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - sync2 == btn_level: the counter clears to 0.
  - sync2 != btn_level, counter < DEBOUNCE_CYCLES-1: the counter increments.
  - sync2 != btn_level, counter == DEBOUNCE_CYCLES-1: btn_level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles clears the counter and produces no output change.
- Strobes:
  - btn_press is asserted in the same cycle btn_level first reads 1.
  - btn_release is asserted in the same cycle btn_level first reads 0.
  - Each strobe is exactly one cycle wide and registered.
- Buttons are fully independent. Simultaneous transitions on several buttons produce simultaneous strobes.
- No FSM beyond the per-button 2-state level (RELEASED, PRESSED). The transition condition is the debounce counter reaching its terminal value.

## Timing

- Reset values: btn_level = 0, btn_press = 0, btn_release = 0; all counters and synchroniser flops = 0.
- Latency: if btn_raw changes before edge E and stays stable, btn_level and the strobe appear after edge E+1+DEBOUNCE_CYCLES (2 synchroniser stages + DEBOUNCE_CYCLES counter cycles).
- A raw pulse of exactly DEBOUNCE_CYCLES cycles at sync2 is accepted. A pulse of DEBOUNCE_CYCLES-1 cycles is rejected.
- DEBOUNCE_CYCLES = 1: the output follows sync2 with one cycle of delay.
- Reset mid-operation: all state is cleared. A button still held after reset is re-debounced from 0 and produces a fresh btn_press after the full latency.
- btn_press and btn_release are never asserted in the same cycle for the same bit.

## Configuration

- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each button with REPEAT_MASK[i] = 1 has a hold counter (32 bit). It clears when btn_level[i] = 0 and counts while btn_level[i] = 1.
  - An extra one-cycle btn_press[i] fires REPEAT_DELAY cycles after the original press strobe.
  - Further strobes follow every REPEAT_PERIOD cycles while the button is held.
  - Release stops repetition immediately; no repeat strobe in the release cycle.
- Undefined: no hold counters are instantiated; btn_press fires only on accepted 0→1 transitions; REPEAT_* parameters are ignored.

## Test plan

Simulation uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- Reset check: hold rst_n=0 with btn_raw=5'b11111 → all outputs 0. Release reset → btn_level=5'b11111 and btn_press=5'b11111 for one cycle, exactly 6 edges later.
- Clean press of button 0: btn_raw[0] rises and stays high → btn_press[0]=1 for one cycle 6 edges later, btn_level[0] stays 1. Drop btn_raw[0] → btn_release[0] pulses 6 edges later.
- Glitch rejection: 3-cycle high pulse on btn_raw[2] → no change on any output. A 4-cycle pulse → one btn_press[2] and one btn_release[2].
- Bounce: btn_raw[3] toggles every 2 cycles for 20 cycles, then stays high → exactly one btn_press[3], 6 edges after the final rise.
- Simultaneous: buttons 1 and 4 pressed in the same cycle → btn_press=5'b10010 in a single cycle.
- Auto-repeat (BTN_AUTOREPEAT_EN): hold buttons 1 and 0 → btn_press[1] pulses at t, t+10, t+13, t+16…; btn_press[0] pulses only at t. Release → no further strobes.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned level/strobe outputs of button_conditioner.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (output btn_raw, input btn_level, btn_press, btn_release);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the board push-buttons in the pixel_clk domain.
// Optional auto-repeat of held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int unsigned      N_BTN           = 5,
    parameter int unsigned      DEBOUNCE_CYCLES = 252000,
    parameter int unsigned      REPEAT_DELAY    = 12600000,
    parameter int unsigned      REPEAT_PERIOD   = 2520000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(5'b11110)
) (
    input logic                 pixel_clk,
    input logic                 rst_n,
    button_conditioner_if.slave btn
);

    localparam int unsigned      CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StReleased, StPressed} btn_state_e;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_MASK != '0 && (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY))
    begin : g_bad_repeat
        $error("REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
    end

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] level;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [CntW-1:0] cnt_q, cnt_d;
        btn_state_e      state_q, state_d;
        logic            toggle, rise, fall, rpt;

        always_comb begin
            cnt_d  = cnt_q;
            toggle = 1'b0;
            if (sync2_q[i] == (state_q == StPressed)) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                cnt_d  = '0;
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            rise    = 1'b0;
            fall    = 1'b0;
            unique case (state_q)
                StReleased: if (toggle) begin
                    state_d = StPressed;
                    rise    = 1'b1;
                end
                StPressed: if (toggle) begin
                    state_d = StReleased;
                    fall    = 1'b1;
                end
            endcase
        end

        always_ff @(posedge pixel_clk) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                state_q <= StReleased;
            end else begin
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        if (REPEAT_MASK[i]) begin : g_rpt
            logic [31:0] hold_q, hold_d;

            // After each repeat the counter is rewound so the next one lands REPEAT_PERIOD later.
            always_comb begin
                hold_d = hold_q;
                rpt    = 1'b0;
                if (state_q == StReleased || toggle) begin
                    hold_d = '0;
                end else if (hold_q == 32'(REPEAT_DELAY - 1)) begin
                    rpt    = 1'b1;
                    hold_d = 32'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end

            always_ff @(posedge pixel_clk) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end
        end else begin : g_no_rpt
            assign rpt = 1'b0;
        end
`else
        assign rpt = 1'b0;
`endif

        assign level[i]     = (state_q == StPressed);
        assign press_d[i]   = rise | rpt;
        assign release_d[i] = fall;
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= btn.btn_raw;
            sync2_q   <= sync1_q;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a window-based reference model.
module tb_button_conditioner;

    localparam int unsigned     NumBtn = 5;
    localparam int unsigned     Db     = 4;
    localparam int unsigned     Rd     = 10;
    localparam int unsigned     Rp     = 3;
    localparam logic [NumBtn-1:0] Mask = 5'b11110;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    typedef struct {
        int unsigned       edge_no;
        logic [NumBtn-1:0] level;
        logic [NumBtn-1:0] press;
        logic [NumBtn-1:0] rel;
    } exp_t;

    logic pixel_clk = 1'b0;
    logic rst_n;
    always #5 pixel_clk = ~pixel_clk;

    button_conditioner_if #(.N_BTN(NumBtn)) bus ();

    button_conditioner #(
        .N_BTN          (NumBtn),
        .DEBOUNCE_CYCLES(Db),
        .REPEAT_DELAY   (Rd),
        .REPEAT_PERIOD  (Rp),
        .REPEAT_MASK    (Mask)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n    (rst_n),
        .btn      (bus)
    );

    int unsigned       edge_cnt = 0;
    int                n_checks = 0;
    int                n_pass   = 0;
    exp_t              lvl_q[$];
    exp_t              ev_q[$];
    exp_t              le, ee;
    logic [NumBtn-1:0] hist[$];
    logic [NumBtn-1:0] m_level = '0;
    int unsigned       press_edge[NumBtn];
    logic [NumBtn-1:0] cur;

    always @(posedge pixel_clk) edge_cnt <= edge_cnt + 1;

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %b, want %b", name, edge_cnt, act, exp);
    endfunction

    // A button changes state once its last Db synchronised samples all disagree with it.
    task automatic model_edge(input logic [NumBtn-1:0] raw, input logic rst);
        exp_t        e;
        bit          all_new;
        int unsigned held;
        e.edge_no = edge_cnt + 1;
        e.press   = '0;
        e.rel     = '0;
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < Db + 2; i++) hist.push_back('0);
            m_level = '0;
        end else begin
            hist.push_back(raw);
            void'(hist.pop_front());
            for (int b = 0; b < NumBtn; b++) begin
                all_new = 1'b1;
                for (int i = 0; i < Db; i++) if (hist[i][b] == m_level[b]) all_new = 1'b0;
                if (all_new) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) begin
                        e.press[b]    = 1'b1;
                        press_edge[b] = e.edge_no;
                    end else begin
                        e.rel[b] = 1'b1;
                    end
                end else if (AutoRep && m_level[b] && Mask[b]) begin
                    held = e.edge_no - press_edge[b];
                    if (held >= Rd && (held - Rd) % Rp == 0) e.press[b] = 1'b1;
                end
            end
        end
        e.level = m_level;
        lvl_q.push_back(e);
        if ((e.press | e.rel) != '0) ev_q.push_back(e);
    endtask

    task automatic step(input logic [NumBtn-1:0] raw, input logic rst);
        bus.btn_raw = raw;
        rst_n       = rst;
        model_edge(raw, rst);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic hold(input logic [NumBtn-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b1);
    endtask

    always @(negedge pixel_clk) begin
        if (lvl_q.size() != 0 && lvl_q[0].edge_no == edge_cnt) begin
            le = lvl_q.pop_front();
            check("level", 16'(bus.btn_level), 16'(le.level));
        end
        if (ev_q.size() != 0 && ev_q[0].edge_no == edge_cnt) begin
            ee = ev_q.pop_front();
            check("press", 16'(bus.btn_press), 16'(ee.press));
            check("release", 16'(bus.btn_release), 16'(ee.rel));
        end else if ((bus.btn_press | bus.btn_release) != '0) begin
            check("spurious_strobe", 16'({bus.btn_press, bus.btn_release}), 16'd0);
        end
    end

    initial begin
        for (int b = 0; b < NumBtn; b++) press_edge[b] = 0;
        bus.btn_raw = '0;
        rst_n       = 1'b0;
        @(posedge pixel_clk);
        #1;

        // Held buttons through reset must come out pressed after the full latency.
        for (int i = 0; i < 3; i++) step(5'b11111, 1'b0);
        hold(5'b11111, 8);
        hold(5'b00000, 8);

        hold(5'b00001, 8);
        hold(5'b00000, 8);

        hold(5'b00100, 3);
        hold(5'b00000, 8);
        hold(5'b00100, 4);
        hold(5'b00000, 8);

        for (int i = 0; i < 20; i++) hold((i / 2) % 2 == 0 ? 5'b01000 : 5'b00000, 1);
        hold(5'b01000, 8);
        hold(5'b00000, 8);

        hold(5'b10010, 8);
        hold(5'b00000, 8);

        hold(5'b00011, 30);
        hold(5'b00000, 8);

        hold(5'b10000, 3);
        step(5'b10000, 1'b0);
        step(5'b10000, 1'b0);
        hold(5'b10000, 8);
        hold(5'b00000, 8);

        cur = '0;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(cur, 1'b0);
                step(cur, 1'b0);
            end
            cur = cur ^ NumBtn'($urandom() & $urandom());
            hold(cur, $urandom_range(1, 7));
        end
        hold(cur, Db + 4);
        hold(5'b00000, Db + 4);

        @(negedge pixel_clk);
        #1;
        check("events_drained", 16'(ev_q.size()), 16'd0);
        check("levels_drained", 16'(lvl_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
